vga_line_pingpong: RTL and testbench

Parametrised double-buffered line store between the SDRAM read path and the VGA pixel pipeline, in a single clock domain. The write side fills one line bank while the read side drains the other. Banks swap automatically on line completion. Full/empty tracking, an explicit read-line flush and sticky overflow/underrun flags replace the free-running pointers of the previous line RAM.

---
 rtl/vga_line_pingpong.sv | 115 +++++++++++
 tb/tb_vga_line_pingpong.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vga_line_pingpong.sv
// Double-buffered line store between the SDRAM read path and the VGA pixel pipeline.
// One bank fills while the other drains; banks swap on line completion or read flush.
module vga_line_pingpong #(
   parameter int DATA_W   = 16,
   parameter int LINE_LEN = 512,
   parameter int AW       = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              rd_en,
   input  logic              rd_flush,
   input  logic              clr_err,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              line_avail,
   output logic [1:0]        lines_ready,
   output logic              overflow,
   output logic              underrun
);

   localparam int            DEPTH    = 2 ** (AW + 1);
   localparam logic [AW-1:0] LAST_IDX = AW'(LINE_LEN - 1);

   logic              wb;
   logic              rb;
   logic [AW-1:0]     wp;
   logic [AW-1:0]     rp;
   logic [1:0]        full;
   logic [1:0]        full_next;
   logic [DATA_W-1:0] mem [DEPTH];

   logic wr_acc;
   logic wr_drop;
   logic do_flush;
   logic rd_acc;
   logic rd_empty;

   assign wr_acc   = wr_en && !full[wb];
   assign wr_drop  = wr_en && full[wb];
   assign do_flush = rd_flush && full[rb];
   assign rd_acc   = rd_en && full[rb] && !rd_flush;
   assign rd_empty = rd_en && !full[rb] && !rd_flush;

   assign wr_ready    = !full[wb];
   assign line_avail  = full[rb];
   assign lines_ready = 2'(full[0]) + 2'(full[1]);

   // Fill of one bank and release of the other can land in the same cycle;
   // wb != rb whenever both happen, so the two updates never collide.
   always_comb begin
      full_next = full;
      if (wr_acc && wp == LAST_IDX)
         full_next[wb] = 1'b1;
      if (do_flush || (rd_acc && rp == LAST_IDX))
         full_next[rb] = 1'b0;
   end

   // NOTE: the line RAM has no reset so it maps onto block RAM; stale contents
   // are harmless because full[] gates every read.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc)
         mem[{wb, wp}] <= wr_data;
   end

   // NOTE: all state uses non-blocking assignments so every read of wp/rp/full
   // below sees the pre-edge value, matching the combinational decode above.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb       <= 1'b0;
         rb       <= 1'b0;
         wp       <= '0;
         rp       <= '0;
         full     <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         overflow <= 1'b0;
         underrun <= 1'b0;
      end else begin
         full     <= full_next;
         rd_data  <= '0;
         rd_valid <= 1'b0;

         if (wr_acc) begin
            if (wp == LAST_IDX) begin
               wp <= '0;
               wb <= ~wb;
            end else begin
               wp <= wp + AW'(1);
            end
         end

         if (do_flush) begin
            rp <= '0;
            rb <= ~rb;
         end else if (rd_acc) begin
            rd_data  <= mem[{rb, rp}];
            rd_valid <= 1'b1;
            if (rp == LAST_IDX) begin
               rp <= '0;
               rb <= ~rb;
            end else begin
               rp <= rp + AW'(1);
            end
         end

         // A fresh error in the clearing cycle keeps the flag set.
         overflow <= (overflow && !clr_err) || wr_drop;
         underrun <= (underrun && !clr_err) || rd_empty;
      end
   end

endmodule

// File: tb/tb_vga_line_pingpong.sv
// Scoreboard bench for vga_line_pingpong with LINE_LEN=8, AW=3: expected pixels are
// queued as they are written and popped whenever the DUT presents rd_valid.
module tb_vga_line_pingpong;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [15:0] wr_data = '0;
   logic        wr_ready;
   logic        rd_en = 1'b0;
   logic        rd_flush = 1'b0;
   logic        clr_err = 1'b0;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        line_avail;
   logic [1:0]  lines_ready;
   logic        overflow;
   logic        underrun;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_q[$];

   vga_line_pingpong #(.DATA_W(16), .LINE_LEN(8), .AW(3)) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_en(rd_en), .rd_flush(rd_flush), .clr_err(clr_err),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .line_avail(line_avail), .lines_ready(lines_ready),
      .overflow(overflow), .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, then score any output pixel.
   task automatic cycle(input logic we, input logic [15:0] wd, input logic re,
                        input logic fl, input logic ce);
      wr_en = we; wr_data = wd; rd_en = re; rd_flush = fl; clr_err = ce;
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0; rd_flush = 1'b0; clr_err = 1'b0;
      if (rd_valid) begin
         if (exp_q.size() == 0) check("rd_extra_valid", 32'(rd_valid), 32'd0);
         else                   check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
   endtask

   task automatic wr_px(input logic [15:0] v, input logic store);
      if (store) exp_q.push_back(v);
      cycle(1'b1, v, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rd_px();
      cycle(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
      check("rd_valid", 32'(rd_valid), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wr_ready"},    32'(wr_ready),    32'd1);
      check({tag, "_line_avail"},  32'(line_avail),  32'd0);
      check({tag, "_lines_ready"}, 32'(lines_ready), 32'd0);
      check({tag, "_rd_valid"},    32'(rd_valid),    32'd0);
      check({tag, "_rd_data"},     32'(rd_data),     32'd0);
      check({tag, "_overflow"},    32'(overflow),    32'd0);
      check({tag, "_underrun"},    32'(underrun),    32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr_i, rd_cnt, gap, cyc;
      logic we, re;

      // Reset state
      do_reset();
      check_reset_outputs("reset");

      // Fill and drain
      for (int i = 1; i <= 8; i++) begin
         wr_px(16'(i), 1'b1);
         if (i == 7) check("fill_avail_early", 32'(line_avail), 32'd0);
      end
      check("fill_line_avail",  32'(line_avail),  32'd1);
      check("fill_lines_ready", 32'(lines_ready), 32'd1);
      for (int i = 0; i < 8; i++) rd_px();
      check("drain_line_avail",  32'(line_avail),  32'd0);
      check("drain_lines_ready", 32'(lines_ready), 32'd0);
      cycle(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
      check("idle_rd_valid", 32'(rd_valid), 32'd0);
      check("idle_rd_data",  32'(rd_data),  32'd0);

      // Overflow: two full lines, then a dropped write
      for (int i = 1; i <= 16; i++) wr_px(16'(i), 1'b1);
      check("ovf_wr_ready",    32'(wr_ready),    32'd0);
      check("ovf_lines_ready", 32'(lines_ready), 32'd2);
      check("ovf_flag_before", 32'(overflow),    32'd0);
      wr_px(16'hAAAA, 1'b0);
      check("ovf_flag", 32'(overflow), 32'd1);
      for (int i = 0; i < 16; i++) rd_px();
      check("ovf_sb_empty",    32'(exp_q.size()), 32'd0);
      check("ovf_lines_after", 32'(lines_ready),  32'd0);
      cycle(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
      check("ovf_cleared", 32'(overflow), 32'd0);

      // Underrun and clear
      do_reset();
      cycle(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
      check("udr_rd_valid", 32'(rd_valid), 32'd0);
      check("udr_rd_data",  32'(rd_data),  32'd0);
      check("udr_flag",     32'(underrun), 32'd1);
      cycle(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
      check("udr_cleared", 32'(underrun), 32'd0);
      cycle(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
      check("udr_clr_same_cycle", 32'(underrun), 32'd1);
      cycle(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
      check("udr_cleared_again", 32'(underrun), 32'd0);

      // Concurrent streaming: write line B while reading line A with gaps
      for (int i = 1; i <= 8; i++) wr_px(16'(i), 1'b1);
      wr_i = 9; rd_cnt = 0; gap = 0; cyc = 0;
      while (rd_cnt < 16 && cyc < 200) begin
         we = (wr_i <= 16);
         re = (gap == 0);
         if (we) exp_q.push_back(16'(wr_i));
         cycle(we, 16'(wr_i), re, 1'b0, 1'b0);
         if (we) wr_i++;
         if (re) begin
            check("stream_rd_valid", 32'(rd_valid), 32'd1);
            rd_cnt++;
            gap = 1 + (rd_cnt % 3);
         end else begin
            gap--;
         end
         check("stream_lines_max", 32'(lines_ready <= 2'd2), 32'd1);
         cyc++;
      end
      check("stream_done",     32'(rd_cnt),       32'd16);
      check("stream_underrun", 32'(underrun),     32'd0);
      check("stream_sb_empty", 32'(exp_q.size()), 32'd0);

      // Flush: two lines stored, read 3, flush, then the next line follows
      for (int i = 1; i <= 16; i++) wr_px(16'(i), (i <= 3) || (i >= 9));
      for (int i = 0; i < 3; i++) rd_px();
      check("flush_lines_before", 32'(lines_ready), 32'd2);
      cycle(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
      check("flush_rd_valid",    32'(rd_valid),    32'd0);
      check("flush_lines_after", 32'(lines_ready), 32'd1);
      check("flush_line_avail",  32'(line_avail),  32'd1);
      for (int i = 0; i < 8; i++) rd_px();
      check("flush_drained",   32'(line_avail),   32'd0);
      check("flush_underrun",  32'(underrun),     32'd0);
      check("flush_sb_empty",  32'(exp_q.size()), 32'd0);

      // Reset mid-operation
      cycle(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
      check("mid_udr_set", 32'(underrun), 32'd1);
      for (int i = 0; i < 8; i++) wr_px(16'(21 + i), i < 2);
      for (int i = 0; i < 5; i++) wr_px(16'(31 + i), 1'b0);
      rd_px();
      rd_px();
      check("mid_sb_empty", 32'(exp_q.size()), 32'd0);
      rst = 1'b1;
      cycle(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      check_reset_outputs("mid_reset");
      for (int i = 0; i < 8; i++) wr_px(16'(41 + i), 1'b1);
      check("post_line_avail", 32'(line_avail),  32'd1);
      check("post_lines",      32'(lines_ready), 32'd1);
      for (int i = 0; i < 8; i++) rd_px();
      check("post_drained",   32'(lines_ready),  32'd0);
      check("post_sb_empty",  32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
